// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a forwarding-less 5-stage pipeline: RAW stalls, data-memory waits, branch flushes.
// Optional macro HAZARD_STATS_EN adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl #(
    parameter int REG_W          = 4,
    parameter int ZERO_REG       = 1,
    parameter int WB_WRITE_FIRST = 1,
    parameter int FLUSH_CYCLES   = 1,
    parameter int MEM_TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rs1,
    input  logic             dec_rs1_used,
    input  logic [REG_W-1:0] dec_rs2,
    input  logic             dec_rs2_used,
    input  logic [REG_W-1:0] exe_rd,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             exe_wr,
    input  logic             mem_wr,
    input  logic             wb_wr,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             fd_stall,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic             pipe_freeze,
    output logic             mem_err,
`ifdef HAZARD_STATS_EN
    output logic [15:0]      raw_stall_cnt,
    output logic [15:0]      mem_stall_cnt,
    output logic [15:0]      flush_cnt,
`endif
    output logic [1:0]       state
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_RAW_STALL = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT  = 2'd2;
    localparam logic [1:0] ST_FLUSH     = 2'd3;

    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [1:0] FL_LAST   = 2'(FLUSH_CYCLES - 1);

    logic [1:0] r_state;
    logic [7:0] r_tmo_cnt;
    logic [1:0] r_fl_cnt;
    logic       r_mem_err;

    logic       w_hit1, w_hit2, w_raw, w_memwait;
    logic       w_pc_stall, w_fd_stall, w_fd_flush, w_de_bubble, w_pipe_freeze;
    logic       w_run_eval, w_mw_eff, w_set_err;
    logic [1:0] w_next_state;
    logic [7:0] w_next_tmo;
    logic [1:0] w_next_fl;

    // Source-vs-destination compare; register 0 and a write-first WB slot never hazard.
    always_comb begin
        w_hit1 = dec_rs1_used
               & ~((ZERO_REG != 0) & (dec_rs1 == {REG_W{1'b0}}))
               & ((exe_wr & (exe_rd == dec_rs1)) | (mem_wr & (mem_rd == dec_rs1))
                  | ((WB_WRITE_FIRST == 0) & wb_wr & (wb_rd == dec_rs1)));
        w_hit2 = dec_rs2_used
               & ~((ZERO_REG != 0) & (dec_rs2 == {REG_W{1'b0}}))
               & ((exe_wr & (exe_rd == dec_rs2)) | (mem_wr & (mem_rd == dec_rs2))
                  | ((WB_WRITE_FIRST == 0) & wb_wr & (wb_rd == dec_rs2)));
        w_raw     = dec_valid & (w_hit1 | w_hit2);
        w_memwait = mem_req & ~mem_ready;
    end

    // Control decode and next-state; RAW_STALL, MEM_WAIT release and RUN share one decision path.
    always_comb begin
        w_pc_stall    = 1'b0;
        w_fd_stall    = 1'b0;
        w_fd_flush    = 1'b0;
        w_de_bubble   = 1'b0;
        w_pipe_freeze = 1'b0;
        w_run_eval    = 1'b0;
        w_mw_eff      = w_memwait;
        w_set_err     = 1'b0;
        w_next_state  = r_state;
        w_next_tmo    = r_tmo_cnt;
        w_next_fl     = r_fl_cnt;
        case (r_state)
            ST_FLUSH: begin
                if (w_memwait) begin
                    w_pc_stall    = 1'b1;
                    w_fd_stall    = 1'b1;
                    w_pipe_freeze = 1'b1;
                    w_next_state  = ST_MEM_WAIT;
                    w_next_tmo    = 8'd1;
                    w_next_fl     = 2'd0;
                end else begin
                    w_fd_flush = 1'b1;
                    if (r_fl_cnt >= FL_LAST) begin
                        w_next_state = ST_RUN;
                        w_next_fl    = 2'd0;
                    end else begin
                        w_next_fl = r_fl_cnt + 2'd1;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (w_memwait && (r_tmo_cnt >= TMO_LIMIT)) begin
                    w_set_err  = 1'b1;
                    w_mw_eff   = 1'b0;
                    w_run_eval = 1'b1;
                end else if (w_memwait) begin
                    w_pc_stall    = 1'b1;
                    w_fd_stall    = 1'b1;
                    w_pipe_freeze = 1'b1;
                    w_next_tmo    = r_tmo_cnt + 8'd1;
                end else begin
                    w_run_eval = 1'b1;
                end
            end
            default: w_run_eval = 1'b1;
        endcase

        if (w_run_eval) begin
            w_next_tmo = 8'd0;
            w_next_fl  = 2'd0;
            if (w_mw_eff) begin
                w_pc_stall    = 1'b1;
                w_fd_stall    = 1'b1;
                w_pipe_freeze = 1'b1;
                w_next_state  = ST_MEM_WAIT;
                w_next_tmo    = 8'd1;
            end else if (w_raw) begin
                w_pc_stall   = 1'b1;
                w_fd_stall   = 1'b1;
                w_de_bubble  = 1'b1;
                w_next_state = w_set_err ? ST_RUN : ST_RAW_STALL;
            end else if (branch_taken) begin
                w_fd_flush = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_next_state = ST_FLUSH;
                    w_next_fl    = 2'd1;
                end else begin
                    w_next_state = ST_RUN;
                end
            end else begin
                w_next_state = ST_RUN;
            end
        end else begin
            w_mw_eff = w_memwait;
        end
    end

    // State, counters and the sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_RUN;
            r_tmo_cnt <= 8'd0;
            r_fl_cnt  <= 2'd0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_tmo_cnt <= w_next_tmo;
            r_fl_cnt  <= w_next_fl;
            r_mem_err <= r_mem_err | w_set_err;
        end
    end

    // Reset low forces every output to 0 regardless of the stored state.
    assign pc_stall    = reset & w_pc_stall;
    assign fd_stall    = reset & w_fd_stall;
    assign fd_flush    = reset & w_fd_flush;
    assign de_bubble   = reset & w_de_bubble;
    assign pipe_freeze = reset & w_pipe_freeze;
    assign mem_err     = reset & r_mem_err;
    assign state       = reset ? r_state : ST_RUN;

`ifdef HAZARD_STATS_EN
    logic [15:0] r_raw_cnt, r_mem_cnt, r_flush_cnt;

    // Saturating cycle counters for stall/freeze/flush activity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_raw_cnt   <= 16'd0;
            r_mem_cnt   <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (de_bubble && (r_raw_cnt != 16'hFFFF)) r_raw_cnt <= r_raw_cnt + 16'd1;
            if (pipe_freeze && (r_mem_cnt != 16'hFFFF)) r_mem_cnt <= r_mem_cnt + 16'd1;
            if (fd_flush && (r_flush_cnt != 16'hFFFF)) r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign raw_stall_cnt = r_raw_cnt;
    assign mem_stall_cnt = r_mem_cnt;
    assign flush_cnt     = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized + directed bench for pipe_hazard_ctrl against a counter-based behavioural model.
module tb_pipe_hazard_ctrl;
    localparam int REG_W          = 4;
    localparam int ZERO_REG       = 1;
    localparam int WB_WRITE_FIRST = 1;
    localparam int FLUSH_CYCLES   = 2;
    localparam int MEM_TIMEOUT    = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset, dec_valid, dec_rs1_used, dec_rs2_used;
    logic [REG_W-1:0] dec_rs1, dec_rs2, exe_rd, mem_rd, wb_rd;
    logic             exe_wr, mem_wr, wb_wr, branch_taken, mem_req, mem_ready;
    logic             pc_stall, fd_stall, fd_flush, de_bubble, pipe_freeze, mem_err;
    logic [1:0]       state;
`ifdef HAZARD_STATS_EN
    logic [15:0]      raw_stall_cnt, mem_stall_cnt, flush_cnt;
    int               m_raw_stat, m_mem_stat, m_fl_stat;
`endif

    pipe_hazard_ctrl #(
        .REG_W(REG_W), .ZERO_REG(ZERO_REG), .WB_WRITE_FIRST(WB_WRITE_FIRST),
        .FLUSH_CYCLES(FLUSH_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs1_used(dec_rs1_used),
        .dec_rs2(dec_rs2), .dec_rs2_used(dec_rs2_used),
        .exe_rd(exe_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .exe_wr(exe_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush),
        .de_bubble(de_bubble), .pipe_freeze(pipe_freeze), .mem_err(mem_err),
`ifdef HAZARD_STATS_EN
        .raw_stall_cnt(raw_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt),
`endif
        .state(state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: number of freeze cycles spent waiting, flush cycles still owed, raw-stall flag, sticky error.
    int m_mem_cnt, m_flush_left;
    bit m_raw_st, m_err;

    // Observed activity counters for the directed segments.
    int obs_stall, obs_freeze, obs_flush;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit src_hit(input logic [REG_W-1:0] rs, input logic used);
        if (!used) return 1'b0;
        if (ZERO_REG != 0 && rs == 0) return 1'b0;
        if (exe_wr && exe_rd == rs) return 1'b1;
        if (mem_wr && mem_rd == rs) return 1'b1;
        if (WB_WRITE_FIRST == 0 && wb_wr && wb_rd == rs) return 1'b1;
        return 1'b0;
    endfunction

    task automatic idle_inputs();
        dec_valid = 1'b0; dec_rs1 = '0; dec_rs1_used = 1'b0; dec_rs2 = '0; dec_rs2_used = 1'b0;
        exe_rd = '0; mem_rd = '0; wb_rd = '0; exe_wr = 1'b0; mem_wr = 1'b0; wb_wr = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // Called just after negedge with inputs driven: checks outputs, advances to next negedge.
    task automatic cycle();
        bit e_stall, e_flush, e_bubble, e_freeze, mw, raw, tmo;
        int e_state, n_mem, n_flush;
        bit n_raw, n_err;
        #1;
        e_stall = 0; e_flush = 0; e_bubble = 0; e_freeze = 0;
        n_mem = m_mem_cnt; n_flush = m_flush_left; n_raw = m_raw_st; n_err = m_err;
        if (!reset) begin
            e_state = 0;
            n_mem = 0; n_flush = 0; n_raw = 0; n_err = 0;
        end else begin
            e_state = (m_mem_cnt > 0) ? 2 : (m_flush_left > 0) ? 3 : m_raw_st ? 1 : 0;
            mw  = mem_req && !mem_ready;
            raw = dec_valid && (src_hit(dec_rs1, dec_rs1_used) || src_hit(dec_rs2, dec_rs2_used));
            if (m_flush_left > 0) begin
                if (mw) begin
                    e_stall = 1; e_freeze = 1; n_mem = 1; n_flush = 0;
                end else begin
                    e_flush = 1; n_flush = m_flush_left - 1;
                end
            end else begin
                tmo = (m_mem_cnt == MEM_TIMEOUT) && mw;
                if (tmo) n_err = 1;
                n_raw = 0;
                if (mw && !tmo) begin
                    e_stall = 1; e_freeze = 1; n_mem = m_mem_cnt + 1;
                end else begin
                    n_mem = 0;
                    if (raw) begin
                        e_stall = 1; e_bubble = 1; n_raw = !tmo;
                    end else if (branch_taken) begin
                        e_flush = 1; n_flush = FLUSH_CYCLES - 1;
                    end
                end
            end
        end
        check_val("pc_stall", 32'(pc_stall), 32'(e_stall));
        check_val("fd_stall", 32'(fd_stall), 32'(e_stall));
        check_val("fd_flush", 32'(fd_flush), 32'(e_flush));
        check_val("de_bubble", 32'(de_bubble), 32'(e_bubble));
        check_val("pipe_freeze", 32'(pipe_freeze), 32'(e_freeze));
        check_val("mem_err", 32'(mem_err), 32'(reset & m_err));
        check_val("state", 32'(state), 32'(e_state));
        obs_stall  += int'(de_bubble);
        obs_freeze += int'(pipe_freeze);
        obs_flush  += int'(fd_flush);
`ifdef HAZARD_STATS_EN
        check_val("raw_stall_cnt", 32'(raw_stall_cnt), 32'(m_raw_stat));
        check_val("mem_stall_cnt", 32'(mem_stall_cnt), 32'(m_mem_stat));
        check_val("flush_cnt", 32'(flush_cnt), 32'(m_fl_stat));
`endif
        @(posedge clk);
`ifdef HAZARD_STATS_EN
        if (!reset) begin
            m_raw_stat = 0; m_mem_stat = 0; m_fl_stat = 0;
        end else begin
            if (e_bubble && m_raw_stat < 65535) m_raw_stat++;
            if (e_freeze && m_mem_stat < 65535) m_mem_stat++;
            if (e_flush && m_fl_stat < 65535) m_fl_stat++;
        end
`endif
        m_mem_cnt = n_mem; m_flush_left = n_flush; m_raw_st = n_raw; m_err = n_err;
        @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_stall = 0; obs_freeze = 0; obs_flush = 0;
    endtask

    initial begin
        int rdy_thr;
        m_mem_cnt = 0; m_flush_left = 0; m_raw_st = 0; m_err = 0;
`ifdef HAZARD_STATS_EN
        m_raw_stat = 0; m_mem_stat = 0; m_fl_stat = 0;
`endif
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);

        // Reset held with hazard/branch/memwait inputs active.
        dec_valid = 1; dec_rs1 = 4'd3; dec_rs1_used = 1; exe_rd = 4'd3; exe_wr = 1;
        branch_taken = 1; mem_req = 1;
        clear_obs();
        repeat (3) cycle();
        check_val("reset_quiet", 32'(obs_stall + obs_freeze + obs_flush), 32'd0);
        idle_inputs(); reset = 1'b1;
        repeat (2) cycle();

        // RAW through EXE then MEM, WB write-first hides the last one.
        clear_obs();
        dec_valid = 1; dec_rs1 = 4'd3; dec_rs1_used = 1; exe_rd = 4'd3; exe_wr = 1;
        cycle();
        exe_wr = 0; mem_rd = 4'd3; mem_wr = 1;
        cycle();
        mem_wr = 0; wb_rd = 4'd3; wb_wr = 1;
        cycle();
        check_val("raw_two_cycles", 32'(obs_stall), 32'd2);
        idle_inputs(); cycle();

        // Register 0 never hazards.
        clear_obs();
        dec_valid = 1; dec_rs2 = 4'd0; dec_rs2_used = 1; exe_rd = 4'd0; exe_wr = 1;
        repeat (2) cycle();
        check_val("zero_reg", 32'(obs_stall), 32'd0);
        idle_inputs(); cycle();

        // Memory wait of 4 cycles then ready.
        clear_obs();
        mem_req = 1; mem_ready = 0;
        repeat (4) cycle();
        mem_ready = 1; cycle();
        check_val("mem_wait4", 32'(obs_freeze), 32'd4);
        check_val("mem_err_clear", 32'(mem_err), 32'd0);
        idle_inputs(); cycle();

        // Memory never ready: timeout releases after MEM_TIMEOUT freeze cycles.
        clear_obs();
        mem_req = 1; mem_ready = 0;
        repeat (MEM_TIMEOUT + 1) cycle();
        check_val("mem_timeout", 32'(obs_freeze), 32'(MEM_TIMEOUT));
        idle_inputs(); repeat (3) cycle();
        check_val("mem_err_sticky", 32'(mem_err), 32'd1);
        check_val("state_after_tmo", 32'(state), 32'd0);

        // Branch together with a RAW hit: stall first, flush after the hazard clears.
        clear_obs();
        dec_valid = 1; dec_rs1 = 4'd5; dec_rs1_used = 1; exe_rd = 4'd5; exe_wr = 1; branch_taken = 1;
        cycle();
        exe_wr = 0; mem_rd = 4'd5; mem_wr = 1;
        cycle();
        check_val("branch_held_by_raw", 32'(obs_flush), 32'd0);
        mem_wr = 0;
        cycle();
        idle_inputs();
        repeat (3) cycle();
        check_val("branch_flush2", 32'(obs_flush), 32'(FLUSH_CYCLES));
        check_val("raw_before_flush", 32'(obs_stall), 32'd2);

        // Randomized phases with varying memory latency and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rdy_thr = ((i / 500) % 2 == 1) ? 1 : 7;
            reset        = ($urandom_range(0, 199) != 0);
            dec_valid    = ($urandom_range(0, 3) != 0);
            dec_rs1      = 4'($urandom_range(0, 3));
            dec_rs2      = 4'($urandom_range(0, 3));
            dec_rs1_used = $urandom_range(0, 1) == 1;
            dec_rs2_used = $urandom_range(0, 1) == 1;
            exe_rd       = 4'($urandom_range(0, 3));
            mem_rd       = 4'($urandom_range(0, 3));
            wb_rd        = 4'($urandom_range(0, 3));
            exe_wr       = $urandom_range(0, 2) == 0;
            mem_wr       = $urandom_range(0, 2) == 0;
            wb_wr        = $urandom_range(0, 1) == 1;
            branch_taken = $urandom_range(0, 4) == 0;
            mem_req      = $urandom_range(0, 3) == 0;
            mem_ready    = $urandom_range(0, 9) < rdy_thr;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
